// File: rtl/step_clk_gen.sv
// ---------------------------------------------------------------------------
// step_clk_gen
//   Generates a slow, stepped clock for a teaching CPU. A step is a high
//   phase of HIGH_CYCLES followed by a low phase of LOW_CYCLES system clocks.
//   Steps are requested manually (key_pulse) or automatically every RUN_DIV
//   idle cycles (run_sel=1). A CPU halt stops stepping until reset, but only
//   after any step in progress has completed.
//
// Ports
//   CLK        in   system clock, rising edge
//   Reset      in   synchronous, active-low reset
//   key_pulse  in   one-cycle step request (debounced)
//   run_sel    in   1 = free-run auto-step, 0 = manual single-step
//   halt_in    in   CPU halt indication (level)
//   cpu_clk    out  registered stepped clock to the CPU
//   busy       out  high while a step (high or low phase) is in progress
//   halted     out  high once the generator has stopped on a CPU halt
//   step_count out  16-bit count of issued steps (wraps)
// ---------------------------------------------------------------------------
module step_clk_gen #(
  parameter int HIGH_CYCLES = 4,
  parameter int LOW_CYCLES  = 4,
  parameter int RUN_DIV     = 1000000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        key_pulse,
  input  logic        run_sel,
  input  logic        halt_in,
  output logic        cpu_clk,
  output logic        busy,
  output logic        halted,
  output logic [15:0] step_count
);

  localparam int PH_MAX = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int RT_W   = $clog2(RUN_DIV);

  localparam logic [PH_W-1:0] HIGH_LAST = PH_W'(HIGH_CYCLES - 1);
  localparam logic [PH_W-1:0] LOW_LAST  = PH_W'(LOW_CYCLES - 1);
  localparam logic [RT_W-1:0] RUN_LAST  = RT_W'(RUN_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIGH,
    ST_LOW,
    ST_HALTED
  } state_t;

  state_t          state_q, state_d;
  logic [PH_W-1:0] phase_q, phase_d;
  logic [RT_W-1:0] timer_q, timer_d;
  logic            pending_q, pending_d;
  logic            halt_req_q, halt_req_d;
  logic            step_inc;

  // Next-state logic. The run timer defaults to zero so it clears whenever
  // the FSM is outside IDLE, in manual mode, or halting.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    timer_d    = '0;
    pending_d  = pending_q;
    halt_req_d = halt_req_q;
    step_inc   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        halt_req_d = 1'b0;
        if (halt_in) begin
          // Halt has priority over any step request arriving this cycle.
          state_d   = ST_HALTED;
          pending_d = 1'b0;
        end else if (run_sel) begin
          pending_d = 1'b0;
          if (timer_q == RUN_LAST) begin
            state_d  = ST_HIGH;
            phase_d  = '0;
            step_inc = 1'b1;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end else if (key_pulse || pending_q) begin
          state_d   = ST_HIGH;
          phase_d   = '0;
          pending_d = 1'b0;
          step_inc  = 1'b1;
        end
      end

      ST_HIGH: begin
        // A halt seen mid-step is remembered so the step still completes.
        if (halt_in) halt_req_d = 1'b1;
        if (!run_sel && key_pulse) pending_d = 1'b1;
        if (phase_q == HIGH_LAST) begin
          state_d = ST_LOW;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      ST_LOW: begin
        if (halt_in) halt_req_d = 1'b1;
        if (!run_sel && key_pulse) pending_d = 1'b1;
        if (phase_q == LOW_LAST) begin
          phase_d = '0;
          if (halt_req_q || halt_in) begin
            state_d    = ST_HALTED;
            pending_d  = 1'b0;
            halt_req_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      ST_HALTED: begin
        // Sticky until reset; all requests are ignored.
        pending_d = 1'b0;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers. Outputs are decoded from the next state so
  // they line up with the state register without any input-to-output path.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      timer_q    <= '0;
      pending_q  <= 1'b0;
      halt_req_q <= 1'b0;
      cpu_clk    <= 1'b0;
      busy       <= 1'b0;
      halted     <= 1'b0;
      step_count <= 16'h0000;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      timer_q    <= timer_d;
      pending_q  <= pending_d;
      halt_req_q <= halt_req_d;
      cpu_clk    <= (state_d == ST_HIGH);
      busy       <= (state_d == ST_HIGH) || (state_d == ST_LOW);
      halted     <= (state_d == ST_HALTED);
      if (step_inc) step_count <= step_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_step_clk_gen.sv
// ---------------------------------------------------------------------------
// tb_step_clk_gen
//   Scoreboard bench for step_clk_gen. Stimulus pushes the expected cpu_clk
//   pulses (rise cycle, step_count at the rise, high length) into a queue;
//   a monitor pops one entry per observed rising edge. Direct checks cover
//   reset state, busy/halted levels, and a second fast instance (HIGH/LOW=1)
//   exercises the 16-bit step_count wrap.
// ---------------------------------------------------------------------------
module tb_step_clk_gen;

  logic        clk = 1'b0;
  logic        Reset, key_pulse, run_sel, halt_in;
  logic        cpu_clk, busy, halted;
  logic [15:0] step_count;

  logic        clk_w = 1'b0;
  logic        Reset_w, key_w;
  logic        run_w, halt_w;
  logic        cpu_clk_w, busy_w, halted_w;
  logic [15:0] step_count_w;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    int rise;
    int cnt;
    int hlen;
  } exp_t;
  exp_t exp_q[$];
  exp_t e_mon;

  always #5 clk = ~clk;
  always #2 clk_w = ~clk_w;
  always @(posedge clk) cyc <= cyc + 1;

  step_clk_gen #(.HIGH_CYCLES(4), .LOW_CYCLES(4), .RUN_DIV(10)) u_dut (
    .CLK(clk), .Reset(Reset), .key_pulse(key_pulse), .run_sel(run_sel),
    .halt_in(halt_in), .cpu_clk(cpu_clk), .busy(busy), .halted(halted),
    .step_count(step_count)
  );

  step_clk_gen #(.HIGH_CYCLES(1), .LOW_CYCLES(1), .RUN_DIV(2)) u_wrap (
    .CLK(clk_w), .Reset(Reset_w), .key_pulse(key_w), .run_sel(run_w),
    .halt_in(halt_w), .cpu_clk(cpu_clk_w), .busy(busy_w), .halted(halted_w),
    .step_count(step_count_w)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int rise, input int cnt, input int hlen);
    exp_t e;
    e.rise = rise;
    e.cnt  = cnt;
    e.hlen = hlen;
    exp_q.push_back(e);
  endtask

  // Advance to 1 time unit after rising edge n; inputs driven here are
  // sampled at edge n+1, outputs read here reflect edge n.
  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every cpu_clk rising edge must match the head of the queue.
  int prev_c = 0;
  int hcnt   = 0;
  int hreq   = 0;
  always @(negedge clk) begin
    if (cpu_clk === 1'b1 && prev_c == 0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse_at_cycle", cyc, -1);
      end else begin
        e_mon = exp_q.pop_front();
        check("rise_cycle", cyc, e_mon.rise);
        check("count_at_rise", int'(step_count), e_mon.cnt);
        hreq = e_mon.hlen;
      end
      hcnt = 1;
    end else if (cpu_clk === 1'b1) begin
      hcnt++;
    end else if (prev_c == 1) begin
      check("high_len", hcnt, hreq);
    end
    prev_c = (cpu_clk === 1'b1) ? 1 : 0;
  end

  // Rising edges of the wrap instance, counted independently of step_count.
  int rise_w = 0;
  int prev_w = 0;
  always @(negedge clk_w) begin
    if (cpu_clk_w === 1'b1 && prev_w == 0) rise_w++;
    prev_w = (cpu_clk_w === 1'b1) ? 1 : 0;
  end

  initial begin
    Reset = 1'b0; key_pulse = 1'b0; run_sel = 1'b0; halt_in = 1'b0;
    Reset_w = 1'b0; key_w = 1'b0; run_w = 1'b0; halt_w = 1'b0;

    // Reset state
    goto(3);
    check("rst_cpu_clk", int'(cpu_clk), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_halted", int'(halted), 0);
    check("rst_count", int'(step_count), 0);
    goto(4);
    Reset = 1'b1;

    // Manual single step: high 11-14, low 15-18
    goto(10);
    push(11, 1, 4);
    key_pulse = 1'b1;
    goto(11); key_pulse = 1'b0;
    goto(12); check("manual_busy_hi", int'(busy), 1);
    goto(19);
    check("manual_busy_lo", int'(busy), 0);
    check("manual_count", int'(step_count), 1);
    check("manual_cpu_clk_lo", int'(cpu_clk), 0);

    // Pending: pulses at 30, 32, 33 -> two steps, second rises at 40
    goto(30);
    push(31, 2, 4);
    push(40, 3, 4);
    key_pulse = 1'b1;
    goto(31); key_pulse = 1'b0;
    goto(32); key_pulse = 1'b1;
    goto(34); key_pulse = 1'b0;
    goto(49);
    check("pending_busy_lo", int'(busy), 0);
    check("pending_count", int'(step_count), 3);

    // Halt mid-step: full pulse, then halted; later keys ignored
    goto(60);
    push(61, 4, 4);
    key_pulse = 1'b1;
    goto(61); key_pulse = 1'b0;
    goto(62); halt_in = 1'b1;
    goto(68); check("halt_not_yet", int'(halted), 0);
    goto(69);
    check("halt_set", int'(halted), 1);
    check("halt_busy", int'(busy), 0);
    goto(72); key_pulse = 1'b1;
    goto(73); key_pulse = 1'b0;
    goto(74); halt_in = 1'b0;
    goto(76); key_pulse = 1'b1;
    goto(77); key_pulse = 1'b0;
    goto(80);
    check("halt_sticky", int'(halted), 1);
    check("halt_count", int'(step_count), 4);

    // Reset out of HALTED, then run mode (RUN_DIV=10 -> period 18)
    goto(82);
    Reset = 1'b0;
    run_sel = 1'b1;
    goto(84);
    check("halt_rst_halted", int'(halted), 0);
    check("halt_rst_count", int'(step_count), 0);
    for (int k = 0; k < 5; k++) push(94 + 18 * k, k + 1, 4);
    Reset = 1'b1;
    goto(100); key_pulse = 1'b1;
    goto(101); key_pulse = 1'b0;
    goto(120); key_pulse = 1'b1;
    goto(121); key_pulse = 1'b0;
    goto(180); run_sel = 1'b0;
    goto(200);
    check("run_count", int'(step_count), 5);
    check("run_busy_lo", int'(busy), 0);

    // Reset mid-HIGH: pulse truncated, key during reset ignored
    goto(210);
    push(211, 6, 2);
    key_pulse = 1'b1;
    goto(211); key_pulse = 1'b0;
    goto(212); Reset = 1'b0;
    goto(213);
    check("midrst_cpu_clk", int'(cpu_clk), 0);
    check("midrst_count", int'(step_count), 0);
    check("midrst_busy", int'(busy), 0);
    key_pulse = 1'b1;
    goto(214); key_pulse = 1'b0;
    goto(215); Reset = 1'b1;
    goto(218);
    push(219, 1, 4);
    key_pulse = 1'b1;
    goto(219); key_pulse = 1'b0;
    goto(230);
    check("post_rst_count", int'(step_count), 1);
    check("post_rst_busy", int'(busy), 0);
    goto(235);
    check("queue_drained", exp_q.size(), 0);

    // Wrap: fast instance with key held high steps every 3 cycles
    repeat (3) @(posedge clk_w);
    #1 Reset_w = 1'b1;
    key_w = 1'b1;
    begin
      int n = 0;
      while (step_count_w != 16'hFFFF && n < 250000) begin
        @(posedge clk_w); #1;
        n++;
      end
      check("wrap_reach_ffff", int'(step_count_w), 16'hFFFF);
      @(negedge clk_w); #1;
      check("wrap_rises_ffff", rise_w, 65535);
      n = 0;
      while (step_count_w == 16'hFFFF && n < 10) begin
        @(posedge clk_w); #1;
        n++;
      end
      check("wrap_to_zero", int'(step_count_w), 0);
      @(negedge clk_w); #1;
      check("wrap_rises_total", rise_w, 65536);
    end
    key_w = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
